watch_set_controller: RTL

Mode and time-setting controller for the digital watch's BCD counter chain. It generates the `increase` strobe for the seconds, minutes and hours upcounter stages. In normal running it chains them from the 1 Hz tick and the stage carries. In setting modes it pauses the time and steers the user's increment button to exactly one stage, with carries suppressed. It also provides a blink phase for the display and an inactivity timeout back to run mode.

---
 rtl/watch_set_if.sv | 23 ++
 rtl/watch_set_controller.sv | 47 ++++
 2 files changed

// File: rtl/watch_set_if.sv
// watch_set_if: pulse inputs, carries and strobe/mode outputs between the watch
// counter chain and its set controller.
interface watch_set_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic       sec_carry;
  logic       min_carry;
  logic       sec_inc;
  logic       min_inc;
  logic       hr_inc;
  logic [1:0] mode;
  logic       setting;
  logic       blink;
  modport master (
    output tick_1hz, btn_mode, btn_inc, sec_carry, min_carry,
    input  sec_inc, min_inc, hr_inc, mode, setting, blink
  );
  modport slave (
    input  tick_1hz, btn_mode, btn_inc, sec_carry, min_carry,
    output sec_inc, min_inc, hr_inc, mode, setting, blink
  );
endinterface

// File: rtl/watch_set_controller.sv
// watch_set_controller: run/set mode FSM steering increment strobes to the
// seconds/minutes/hours stages, with display blink phase and setting timeout.
module watch_set_controller #(
  parameter int TIMEOUT_TICKS = 10
) (
  input logic        clk,
  input logic        rst,
  watch_set_if.slave bus
);
  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] SET_HR  = 2'd1;
  localparam logic [1:0] SET_MIN = 2'd2;
  localparam logic [3:0] LAST    = 4'(TIMEOUT_TICKS - 1);
  logic [1:0] state, state_d;
  logic [3:0] idle, idle_d;
  logic       blink_q, blink_d;
  logic       in_set, press, timeout;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= RUN;
      idle    <= '0;
      blink_q <= 1'b1;
    end else begin
      state   <= state_d;
      idle    <= idle_d;
      blink_q <= blink_d;
    end
  // a button press in the same cycle as a tick restarts the idle count, so the tick earns no credit
  always_comb begin
    in_set  = (state == SET_HR) || (state == SET_MIN);
    press   = bus.btn_mode | bus.btn_inc;
    timeout = in_set && bus.tick_1hz && !press && (idle == LAST);
    state_d = (!in_set && state != RUN) ? RUN :
              bus.btn_mode ? ((state == RUN) ? SET_HR : (state == SET_HR) ? SET_MIN : RUN) :
              timeout ? RUN : state;
    idle_d  = (!in_set || press || timeout) ? 4'd0 : idle + 4'(bus.tick_1hz);
    blink_d = (state == RUN || state_d != state || bus.btn_inc) ? 1'b1 : blink_q ^ bus.tick_1hz;
  end
  always_comb begin
    bus.sec_inc = (state == RUN) & bus.tick_1hz;
    bus.min_inc = (state == RUN) ? bus.sec_carry : (state == SET_MIN) & bus.btn_inc;
    bus.hr_inc  = (state == RUN) ? bus.min_carry : (state == SET_HR) & bus.btn_inc;
    bus.mode    = state;
    bus.setting = in_set;
    bus.blink   = blink_q;
  end
endmodule
